alu_rs_scheduler: RTL
=====================

Name: alu_rs_scheduler

Overview:
- Reservation-station scheduler that owns the single combinational ALU.
- Buffers dispatched ALU/branch/jump ops until both operands are available, capturing missing ones by snooping the CDB.
- Issues one ready op per cycle into an execute latch that drives the ALU, and presents the ALU result with its ROB tag to the CDB arbiter via a valid/ready handshake.

Parameters:
DEPTH, 4, number of station entries (power of 2, ≥2)
TAG_W, 4, ROB tag width

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous active-high reset
rdy_in  in  1  global ready; low freezes all state
flush_in  in  1  misprediction flush; clears station and execute latch
disp_valid  in  1  dispatch request
disp_ready  out  1  at least one free entry
disp_alu_op  in  5  ALU opcode (codebase macro encoding)
disp_addr  in  32  instruction PC
disp_len  in  1  1 = 32-bit instruction, 0 = 16-bit
disp_v1/disp_v2  in  32  operand values when available
disp_p1/disp_p2  in  1  operand pending (value not yet produced)
disp_q1/disp_q2  in  TAG_W  producer tag when pending
disp_dest  in  TAG_W  destination ROB tag
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcast tag
cdb_value  in  32  broadcast value
alu_op1/alu_op2/alu_addr  out  32  ALU operands, from execute latch
alu_op  out  5  ALU opcode, from execute latch
alu_len  out  1  ALU instruction length, from execute latch
alu_result  in  32  ALU result
alu_jalr_done  in  1  ALU JALR flag
alu_jalr_addr  in  32  ALU JALR target
out_valid  out  1  execute latch holds a completed op
out_tag  out  TAG_W  ROB tag of that op
out_value  out  32  equals alu_result
out_jalr_done  out  1  equals alu_jalr_done
out_jalr_addr  out  32  equals alu_jalr_addr
out_ready  in  1  CDB arbiter accepts the result

Behaviour:
- Reset (async, immediate):
  - All entry valid bits = 0; execute latch valid = 0.
  - All registered outputs = 0; disp_ready = 1 once reset deasserts.
- Storage: each entry holds valid, alu_op, addr, len, dest, and for each operand p, q, v.
- disp_ready = OR of ~valid over all entries (combinational). A dispatch is accepted when disp_valid & disp_ready & rdy_in & ~flush_in.
  - Write target: lowest-index free entry.
- Dispatch bypass: if operand pending and cdb_valid and cdb_tag == disp_q in the same cycle, store p=0 and v=cdb_value.
- Wakeup: each cycle, every valid entry with p=1 and q == cdb_tag (cdb_valid) sets p=0, v=cdb_value at the edge.
  - The entry becomes issue-eligible the following cycle (no same-cycle wakeup-issue).
- Ready entry: valid & ~p1 & ~p2. Selection: lowest-index ready entry (fixed priority).
- Execute latch advance: fire = ~ex_valid | out_ready.
  - On fire with a selected entry: latch its fields, set ex_valid=1, clear the entry's valid.
  - On fire with no ready entry: ex_valid=0.
  - Without fire: latch holds; outputs stable while out_valid & ~out_ready.
- The freed entry is reusable by dispatch from the next cycle. The same entry is never both issued and written in one cycle.
- ALU is combinational: out_valid = ex_valid, out_tag = ex_dest, out_value = alu_result.
- Latency: dispatch with both operands ready at edge t → out_valid asserted after edge t+1 (2 cycles). With out_ready held high, sustained throughput is 1 op/cycle.
- Full: disp_ready=0; issue in the same cycle does not make disp_ready 1 until the next cycle.
- flush_in (synchronous, rdy_in-independent, highest priority): all entry valids = 0, ex_valid = 0 at the next edge; the concurrent dispatch is dropped.
- rdy_in low: no dispatch, wakeup, issue or latch change. CDB is guaranteed idle while rdy_in is low.
- Reset mid-operation discards all entries and the latch immediately.

Test Plan:
- Reset then dispatch ADD with v1=5, v2=7, both ready, dest=3; out_ready=1 → out_valid high 2 cycles later with out_tag=3, out_value=12; disp_ready stays 1.
- Dispatch SUB with p1=1, q1=6 → no issue. CDB tag 6, value 20 one cycle later; v2=8 → out_value=12 two cycles after the broadcast edge.
- Dispatch while cdb_valid with cdb_tag equal to disp_q2=2, value 9 (bypass) → entry ready immediately; result appears 2 cycles after dispatch.
- Fill 4 entries (all waiting) → disp_ready=0 and a 5th dispatch is not accepted. Wake entry 2 → it issues first; disp_ready=1 the cycle after issue.
- Hold out_ready=0 with a result pending and ready entries queued → out_tag/out_value stable and no entry issued. Release → back-to-back results, one per cycle, lowest index first.
- Mid-stream flush_in pulse with 3 entries and out_valid=1 → next cycle out_valid=0, disp_ready=1, and no further results appear.

Source files
------------

// File: rtl/alu_rs_scheduler_if.sv
// Dispatch, CDB snoop, ALU and result-handshake signals of the ALU reservation-station scheduler.
// The master side is the surrounding core; the slave side is the scheduler.
interface alu_rs_scheduler_if #(
    parameter int TAG_W = 4
);
    // Dispatch
    logic             disp_valid;
    logic             disp_ready;
    logic [4:0]       disp_alu_op;
    logic [31:0]      disp_addr;
    logic             disp_len;
    logic [31:0]      disp_v1;
    logic [31:0]      disp_v2;
    logic             disp_p1;
    logic             disp_p2;
    logic [TAG_W-1:0] disp_q1;
    logic [TAG_W-1:0] disp_q2;
    logic [TAG_W-1:0] disp_dest;

    // Common data bus snoop
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;

    // Combinational ALU
    logic [31:0]      alu_op1;
    logic [31:0]      alu_op2;
    logic [31:0]      alu_addr;
    logic [4:0]       alu_op;
    logic             alu_len;
    logic [31:0]      alu_result;
    logic             alu_jalr_done;
    logic [31:0]      alu_jalr_addr;

    // Result toward the CDB arbiter
    logic             out_valid;
    logic [TAG_W-1:0] out_tag;
    logic [31:0]      out_value;
    logic             out_jalr_done;
    logic [31:0]      out_jalr_addr;
    logic             out_ready;

    modport master (
        output disp_valid, disp_alu_op, disp_addr, disp_len,
               disp_v1, disp_v2, disp_p1, disp_p2, disp_q1, disp_q2, disp_dest,
               cdb_valid, cdb_tag, cdb_value,
               alu_result, alu_jalr_done, alu_jalr_addr,
               out_ready,
        input  disp_ready,
               alu_op1, alu_op2, alu_addr, alu_op, alu_len,
               out_valid, out_tag, out_value, out_jalr_done, out_jalr_addr
    );

    modport slave (
        input  disp_valid, disp_alu_op, disp_addr, disp_len,
               disp_v1, disp_v2, disp_p1, disp_p2, disp_q1, disp_q2, disp_dest,
               cdb_valid, cdb_tag, cdb_value,
               alu_result, alu_jalr_done, alu_jalr_addr,
               out_ready,
        output disp_ready,
               alu_op1, alu_op2, alu_addr, alu_op, alu_len,
               out_valid, out_tag, out_value, out_jalr_done, out_jalr_addr
    );
endinterface

// File: rtl/alu_rs_scheduler.sv
// Reservation station in front of the single combinational ALU: buffers ops until both operands
// are known, snoops the CDB for missing ones, and issues one ready op per cycle into the execute latch.
module alu_rs_scheduler #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    alu_rs_scheduler_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0]       alu_op;
        logic [31:0]      addr;
        logic             len;
        logic [TAG_W-1:0] dest;
        logic             p1;
        logic [TAG_W-1:0] q1;
        logic [31:0]      v1;
        logic             p2;
        logic [TAG_W-1:0] q2;
        logic [31:0]      v2;
    } entry_t;

    typedef struct packed {
        logic [31:0]      op1;
        logic [31:0]      op2;
        logic [31:0]      addr;
        logic [4:0]       op;
        logic             len;
        logic [TAG_W-1:0] dest;
    } ex_t;

    logic [DEPTH-1:0] valid_q, valid_d;
    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    ex_t              ex_q, ex_d;
    logic             ex_valid_q, ex_valid_d;

    logic [DEPTH-1:0] ready_vec;
    logic             any_ready, any_free;
    logic [IDX_W-1:0] sel_idx, free_idx;
    logic             fire, disp_accept;
    logic             byp1, byp2;
    entry_t           new_ent;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = valid_q[i] & ~ent_q[i].p1 & ~ent_q[i].p2;
        end
    end

    // Fixed-priority pickers; the downward scan leaves the lowest matching index.
    always_comb begin
        any_ready = 1'b0;
        sel_idx   = '0;
        any_free  = 1'b0;
        free_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                any_ready = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign fire        = ~ex_valid_q | bus.out_ready;
    assign disp_accept = bus.disp_valid & any_free & rdy_in & ~flush_in;

    assign byp1 = bus.disp_p1 & bus.cdb_valid & (bus.cdb_tag == bus.disp_q1);
    assign byp2 = bus.disp_p2 & bus.cdb_valid & (bus.cdb_tag == bus.disp_q2);

    always_comb begin
        new_ent.alu_op = bus.disp_alu_op;
        new_ent.addr   = bus.disp_addr;
        new_ent.len    = bus.disp_len;
        new_ent.dest   = bus.disp_dest;
        new_ent.p1     = bus.disp_p1 & ~byp1;
        new_ent.q1     = bus.disp_q1;
        new_ent.v1     = byp1 ? bus.cdb_value : bus.disp_v1;
        new_ent.p2     = bus.disp_p2 & ~byp2;
        new_ent.q2     = bus.disp_q2;
        new_ent.v2     = byp2 ? bus.cdb_value : bus.disp_v2;
    end

    always_comb begin
        // NOTE: every next-state variable gets a hold default first so no path leaves it unassigned (no latch).
        valid_d    = valid_q;
        ent_d      = ent_q;
        ex_d       = ex_q;
        ex_valid_d = ex_valid_q;

        if (flush_in) begin
            valid_d    = '0;
            ex_valid_d = 1'b0;
        end else if (rdy_in) begin
            // Wakeup lands at the edge; ready_vec sees it only next cycle.
            if (bus.cdb_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid_q[i] && ent_q[i].p1 && ent_q[i].q1 == bus.cdb_tag) begin
                        ent_d[i].p1 = 1'b0;
                        ent_d[i].v1 = bus.cdb_value;
                    end
                    if (valid_q[i] && ent_q[i].p2 && ent_q[i].q2 == bus.cdb_tag) begin
                        ent_d[i].p2 = 1'b0;
                        ent_d[i].v2 = bus.cdb_value;
                    end
                end
            end

            if (fire) begin
                if (any_ready) begin
                    ex_d.op1         = ent_q[sel_idx].v1;
                    ex_d.op2         = ent_q[sel_idx].v2;
                    ex_d.addr        = ent_q[sel_idx].addr;
                    ex_d.op          = ent_q[sel_idx].alu_op;
                    ex_d.len         = ent_q[sel_idx].len;
                    ex_d.dest        = ent_q[sel_idx].dest;
                    ex_valid_d       = 1'b1;
                    valid_d[sel_idx] = 1'b0;
                end else begin
                    ex_valid_d = 1'b0;
                end
            end

            // free_idx comes from valid_q, so it can never alias the entry being issued.
            if (disp_accept) begin
                valid_d[free_idx] = 1'b1;
                ent_d[free_idx]   = new_ent;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q    <= '0;
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
            valid_q    <= valid_d;
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
        end
    end

    // NOTE: entry payload is not reset; valid_q alone decides whether it is ever read.
    always_ff @(posedge clk_in) begin
        ent_q <= ent_d;
    end

    assign bus.disp_ready    = any_free;
    assign bus.alu_op1       = ex_q.op1;
    assign bus.alu_op2       = ex_q.op2;
    assign bus.alu_addr      = ex_q.addr;
    assign bus.alu_op        = ex_q.op;
    assign bus.alu_len       = ex_q.len;
    assign bus.out_valid     = ex_valid_q;
    assign bus.out_tag       = ex_q.dest;
    assign bus.out_value     = bus.alu_result;
    assign bus.out_jalr_done = bus.alu_jalr_done;
    assign bus.out_jalr_addr = bus.alu_jalr_addr;

endmodule
